// File: rtl/axis_upsizer.sv
// rtl/axis_upsizer.sv - packs RATIO narrow stream beats into one wide word, flushing early on tlast
module axis_upsizer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  input  logic [WIDTH-1:0]       s_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [RATIO-1:0]       m_tkeep,
  output logic [WIDTH*RATIO-1:0] m_tdata
);

  localparam int OUTW  = WIDTH * RATIO;
  localparam int CBITS = $clog2(RATIO);
  localparam logic [CBITS-1:0] LAST_LANE = CBITS'(RATIO - 1);

  if (RATIO < 2) begin : g_bad_ratio
    $error("axis_upsizer: RATIO must be at least 2");
  end

  logic [CBITS-1:0] lane_cnt;
  logic [OUTW-1:0]  acc_data;
  logic [RATIO-1:0] acc_keep;
  logic [OUTW-1:0]  merged_data;
  logic [RATIO-1:0] merged_keep;
  logic             accept;
  logic             closing;

  assign s_tready = !reset && (!m_tvalid || m_tready);
  assign accept   = s_tvalid && s_tready;
  assign closing  = accept && (s_tlast || (lane_cnt == LAST_LANE));

  // Accumulator lanes below the counter, the incoming beat at the counter, zeros above.
  always_comb begin
    merged_data = '0;
    merged_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(lane_cnt)) begin
        merged_data[i*WIDTH +: WIDTH] = acc_data[i*WIDTH +: WIDTH];
        merged_keep[i]                = acc_keep[i];
      end else if (i == int'(lane_cnt)) begin
        merged_data[i*WIDTH +: WIDTH] = s_tdata;
        merged_keep[i]                = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_cnt <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tkeep  <= '0;
      m_tdata  <= '0;
    end else if (closing) begin
      // s_tready guarantees any current word retires this cycle, so loading is safe.
      m_tdata  <= merged_data;
      m_tkeep  <= merged_keep;
      m_tlast  <= s_tlast;
      m_tvalid <= 1'b1;
      acc_data <= '0;
      acc_keep <= '0;
      lane_cnt <= '0;
    end else begin
      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (accept) begin
        acc_data <= merged_data;
        acc_keep <= merged_keep;
        lane_cnt <= lane_cnt + CBITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// tb/tb_axis_upsizer.sv - directed self-checking bench for axis_upsizer
module tb_axis_upsizer;

  logic        clock;
  logic        reset;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [3:0]  m_tkeep;
  logic [31:0] m_tdata;

  int checks = 0;
  int errors = 0;

  axis_upsizer #(.WIDTH(8), .RATIO(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tkeep  (m_tkeep),
    .m_tdata  (m_tdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
    tick(); tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
    checks++; if (m_tkeep !== 4'h0) begin errors++; $display("FAIL reset_tkeep got %h want 0", m_tkeep); end
    checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_tready); end
    reset = 1'b0;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b want 1", s_tready); end
  endtask

  task automatic test_full_words;
    logic [7:0] beats [4];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = beats[i];
      tick();
      if (i < 3) begin
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL full_early_valid beat %0d got %b want 0", i, m_tvalid); end
      end
    end
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", m_tvalid); end
    checks++; if (m_tdata !== 32'h44332211) begin errors++; $display("FAIL full_data got %h want 44332211", m_tdata); end
    checks++; if (m_tkeep !== 4'b1111) begin errors++; $display("FAIL full_keep got %b want 1111", m_tkeep); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL full_last got %b want 0", m_tlast); end
    tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL full_retire got %b want 0", m_tvalid); end
  endtask

  task automatic test_partial_flush;
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'hAA; tick();
    s_tlast = 1'b1; s_tdata = 8'hBB; tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tdata !== 32'h0000BBAA) begin errors++; $display("FAIL partial_data got %h want 0000bbaa", m_tdata); end
    checks++; if (m_tkeep !== 4'b0011) begin errors++; $display("FAIL partial_keep got %b want 0011", m_tkeep); end
    checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL partial_last got %b want 1", m_tlast); end
    s_tvalid = 1'b1; s_tdata = 8'hCC; tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL partial_retire got %b want 0", m_tvalid); end
    s_tlast = 1'b1; s_tdata = 8'hDD; tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tdata !== 32'h0000DDCC) begin errors++; $display("FAIL next_lane0_data got %h want 0000ddcc", m_tdata); end
    checks++; if (m_tkeep !== 4'b0011) begin errors++; $display("FAIL next_lane0_keep got %b want 0011", m_tkeep); end
  endtask

  task automatic test_single_beat;
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 8'h5A; tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", m_tvalid); end
    checks++; if (m_tdata !== 32'h0000005A) begin errors++; $display("FAIL single_data got %h want 0000005a", m_tdata); end
    checks++; if (m_tkeep !== 4'b0001) begin errors++; $display("FAIL single_keep got %b want 0001", m_tkeep); end
    checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL single_last got %b want 1", m_tlast); end
    tick();
  endtask

  task automatic test_backpressure;
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'(i + 1);
      tick();
    end
    // Offer a closing beat that must wait for the stall to clear.
    s_tdata = 8'h99; s_tlast = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL stall_tready cycle %0d got %b want 0", c, s_tready); end
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h04030201 || m_tkeep !== 4'hF || m_tlast !== 1'b0) begin
        errors++; $display("FAIL stall_hold cycle %0d got v%b d%h k%h l%b want v1 d04030201 kf l0", c, m_tvalid, m_tdata, m_tkeep, m_tlast);
      end
      tick();
    end
    m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b want 1", s_tready); end
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h00000099 || m_tkeep !== 4'b0001 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL retire_reload got v%b d%h k%b l%b want v1 d00000099 k0001 l1", m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", m_tvalid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [4];
    words[0] = 32'h03020100; words[1] = 32'h07060504;
    words[2] = 32'h0B0A0908; words[3] = 32'h0F0E0D0C;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'(i);
      #1;
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL b2b_tready beat %0d got %b want 1", i, s_tready); end
      tick();
      if (i % 4 == 3) begin
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== words[i/4] || m_tkeep !== 4'hF) begin
          errors++; $display("FAIL b2b_word %0d got v%b d%h k%h want v1 d%h kf", i/4, m_tvalid, m_tdata, m_tkeep, words[i/4]);
        end
      end else if (i % 4 == 0 && i > 0) begin
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_retire beat %0d got %b want 0", i, m_tvalid); end
      end
    end
    s_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] beats [4];
    beats[0] = 8'h33; beats[1] = 8'h44; beats[2] = 8'h55; beats[3] = 8'h66;
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'h11; tick();
    s_tdata = 8'h22; tick();
    s_tvalid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL midrst_tready got %b want 0", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", m_tvalid); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = beats[i];
      tick();
    end
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h66554433 || m_tkeep !== 4'hF) begin
      errors++; $display("FAIL midrst_word got v%b d%h k%h want v1 d66554433 kf", m_tvalid, m_tdata, m_tkeep);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_flush();
    test_single_beat();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
